// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_ALIGN = 4;

  localparam logic [XLEN-1:0] DEFAULT_RESET_ADDR = 32'h0000_0000;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    OUT,
    HALTED
  } fetch_state_e;

  // Force a jump target onto an instruction boundary.
  function automatic logic [XLEN-1:0] align_addr(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Single-outstanding request/grant/response bus to instruction memory.
interface fetch_ctrl_if;
  import fetch_pkg::*;

  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_gnt_i;
  logic            imem_rvalid_i;
  logic [XLEN-1:0] imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_gnt_i,
    input  imem_rvalid_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_gnt_i,
    output imem_rvalid_i,
    output imem_rdata_i
  );

endinterface

// File: rtl/fetch_ctrl_pc_reg.sv
// Program counter: loads an aligned target or advances by one instruction.
module pc_reg
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_ADDR = DEFAULT_RESET_ADDR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            inc,
  input  logic [XLEN-1:0] load_addr,
  output logic [XLEN-1:0] pc
);

  // Load has priority; the increment wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_ADDR;
    end else if (load) begin
      pc <= align_addr(load_addr);
    end else if (inc) begin
      pc <= pc + XLEN'(INSTR_ALIGN);
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: PC ownership, imem handshake, decode handoff,
// and redirect/trap/halt handling. Every output is a flop.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_ADDR = DEFAULT_RESET_ADDR
) (
  input  logic            clk,
  input  logic            rst_n,
  fetch_ctrl_if.master    imem,
  output logic            instr_valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  input  logic            instr_ready_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic            halt_i,
  input  logic            resume_i,
  output logic [XLEN-1:0] pc_o,
  output logic            misalign_o
);

  fetch_state_e    state, state_d;
  logic            kill, kill_d;
  logic            halt_pend, halt_pend_d;
  logic            flush;
  logic [XLEN-1:0] target;
  logic            pc_load, pc_inc, capture;
  logic            misalign_d;
  logic            req_q;
  logic [XLEN-1:0] addr_q, addr_d;

  assign imem.imem_req_o  = req_q;
  assign imem.imem_addr_o = addr_q;

  pc_reg #(.RESET_ADDR(RESET_ADDR)) u_pc (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (pc_load),
    .inc       (pc_inc),
    .load_addr (target),
    .pc        (pc_o)
  );

  // Next-state, PC control and kill/halt bookkeeping.
  always_comb begin
    flush       = trap_i | redirect_i;
    target      = trap_i ? mtvec_i : redirect_pc_i;
    state_d     = state;
    kill_d      = kill;
    halt_pend_d = halt_pend;
    pc_load     = flush;
    pc_inc      = 1'b0;
    capture     = 1'b0;
    misalign_d  = flush && (target[1:0] != 2'b00);

    case (state)
      IDLE: begin
        state_d = REQ;
        if (!flush && halt_i) begin
          halt_pend_d = 1'b1;
          kill_d      = 1'b1;
        end
      end
      REQ: begin
        // The request cannot be withdrawn, so control changes only mark
        // its response for discard.
        if (imem.imem_gnt_i) state_d = WAIT;
        if (flush) begin
          kill_d      = 1'b1;
          halt_pend_d = 1'b0;
        end else if (halt_i) begin
          kill_d      = 1'b1;
          halt_pend_d = 1'b1;
        end
      end
      WAIT: begin
        if (imem.imem_rvalid_i) begin
          if (kill || flush || halt_i) begin
            kill_d      = 1'b0;
            halt_pend_d = 1'b0;
            state_d     = (!flush && (halt_pend || halt_i)) ? HALTED : REQ;
          end else begin
            capture = 1'b1;
            pc_inc  = 1'b1;
            state_d = OUT;
          end
        end else if (flush) begin
          kill_d      = 1'b1;
          halt_pend_d = 1'b0;
        end else if (halt_i) begin
          kill_d      = 1'b1;
          halt_pend_d = 1'b1;
        end
      end
      OUT: begin
        if (flush)              state_d = REQ;
        else if (halt_i)        state_d = HALTED;
        else if (instr_ready_i) state_d = REQ;
      end
      HALTED: begin
        if (flush || (resume_i && !halt_i)) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase

    // The request address is fixed when a request starts and held until granted.
    if (state != REQ && state_d == REQ) begin
      addr_d = pc_load ? align_addr(target) : pc_o;
    end else begin
      addr_d = addr_q;
    end
  end

  // State register and registered control outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      kill          <= 1'b0;
      halt_pend     <= 1'b0;
      req_q         <= 1'b0;
      addr_q        <= RESET_ADDR;
      instr_valid_o <= 1'b0;
      misalign_o    <= 1'b0;
    end else begin
      state         <= state_d;
      kill          <= kill_d;
      halt_pend     <= halt_pend_d;
      req_q         <= (state_d == REQ);
      addr_q        <= addr_d;
      instr_valid_o <= (state_d == OUT);
      misalign_o    <= misalign_d;
    end
  end

  // Held instruction and its address, captured from an accepted response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_o    <= '0;
      instr_pc_o <= '0;
    end else if (capture) begin
      instr_o    <= imem.imem_rdata_i;
      instr_pc_o <= pc_o;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: memory responder, directed vectors and a
// randomized run against an instruction-stream model.
module tb_fetch_ctrl;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid, instr_ready, redirect, trap, halt, resume, misalign;
  logic [31:0] instr, instr_pc, redirect_pc, mtvec, pc;

  always #5 clk = ~clk;

  fetch_ctrl_if bus();

  fetch_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem          (bus),
    .instr_valid_o (instr_valid),
    .instr_o       (instr),
    .instr_pc_o    (instr_pc),
    .instr_ready_i (instr_ready),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .trap_i        (trap),
    .mtvec_i       (mtvec),
    .halt_i        (halt),
    .resume_i      (resume),
    .pc_o          (pc),
    .misalign_o    (misalign)
  );

  int checks = 0;
  int failures = 0;

  // Memory responder configuration
  int lat_min = 0, lat_max = 0, gnt_pct = 100, gnt_block = 0;
  bit mem_nop = 1'b0;
  bit last_gnt = 1'b0, pending = 1'b0;
  int cnt = 0;
  logic [31:0] last_addr = '0, paddr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_nop) return 32'h0000_0013;
    return 32'h0000_0013 | (a << 7);
  endfunction

  always @(negedge clk) begin
    bus.imem_rvalid_i = 1'b0;
    if (last_gnt) begin
      pending  = 1'b1;
      cnt      = $urandom_range(lat_max, lat_min);
      paddr    = last_addr;
      last_gnt = 1'b0;
    end
    if (pending) begin
      if (cnt == 0) begin
        bus.imem_rvalid_i = 1'b1;
        bus.imem_rdata_i  = mem_word(paddr);
        pending = 1'b0;
      end else begin
        cnt--;
      end
    end
    bus.imem_gnt_i = 1'b0;
    if (bus.imem_req_o === 1'b1) begin
      if (gnt_block > 0) gnt_block--;
      else if ($urandom_range(99, 0) < gnt_pct) begin
        bus.imem_gnt_i = 1'b1;
        last_gnt  = 1'b1;
        last_addr = bus.imem_addr_o;
      end
    end
  end

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    instr_ready = 1'b0; redirect = 1'b0; trap = 1'b0; halt = 1'b0; resume = 1'b0;
    redirect_pc = '0; mtvec = '0;
  endtask

  task automatic check_reset_values(input string tag);
    check1 ({tag, "_req"},      bus.imem_req_o,  1'b0);
    check32({tag, "_addr"},     bus.imem_addr_o, 32'h0);
    check1 ({tag, "_valid"},    instr_valid,     1'b0);
    check32({tag, "_instr"},    instr,           32'h0);
    check32({tag, "_instr_pc"}, instr_pc,        32'h0);
    check32({tag, "_pc"},       pc,              32'h0);
    check1 ({tag, "_misalign"}, misalign,        1'b0);
  endtask

  // Holds reset long enough for any in-flight memory response to drain.
  task automatic do_reset(input int blk);
    rst_n = 1'b0;
    clear_inputs();
    repeat (6) tick();
    check_reset_values("reset");
    gnt_block = blk;
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input int max, input string name);
    bit found = 1'b0;
    for (int i = 0; i < max && !found; i++) begin
      tick();
      if (instr_valid) found = 1'b1;
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL %s: got no instr_valid expected one within %0d cycles", name, max);
    end
  endtask

  typedef struct {
    logic        ready;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] ipc;
    logic [31:0] pcv;
  } vec_t;

  vec_t vt[9];

  initial begin
    bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b0; bus.imem_rdata_i = '0;
    clear_inputs();

    // Zero-wait memory, decode always ready: one instruction per 3 cycles.
    vt[0] = '{1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0};
    vt[1] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0};
    vt[2] = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h0, 32'h4};
    vt[3] = '{1'b1, 1'b1, 32'h4, 1'b0, 32'h0, 32'h4};
    vt[4] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h4};
    vt[5] = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h4, 32'h8};
    vt[6] = '{1'b1, 1'b1, 32'h8, 1'b0, 32'h0, 32'h8};
    vt[7] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h8};
    vt[8] = '{1'b1, 1'b0, 32'h0, 1'b1, 32'h8, 32'hC};

    mem_nop = 1'b1; lat_min = 0; lat_max = 0; gnt_pct = 100;
    do_reset(0);
    instr_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      check1 ($sformatf("seq%0d_req", i), bus.imem_req_o, vt[i].req);
      if (vt[i].req) check32($sformatf("seq%0d_addr", i), bus.imem_addr_o, vt[i].addr);
      check1 ($sformatf("seq%0d_valid", i), instr_valid, vt[i].valid);
      if (vt[i].valid) begin
        check32($sformatf("seq%0d_instr_pc", i), instr_pc, vt[i].ipc);
        check32($sformatf("seq%0d_instr", i), instr, 32'h0000_0013);
      end
      check32($sformatf("seq%0d_pc", i), pc, vt[i].pcv);
      instr_ready = vt[i].ready;
    end
    mem_nop = 1'b0;

    // Redirect while the first request waits for a withheld grant.
    do_reset(3);
    instr_ready = 1'b1;
    tick();
    check32("stall_addr0", bus.imem_addr_o, 32'h0);
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    check32("stall_pc", pc, 32'h100);
    for (int i = 0; i < 3; i++) begin
      check1 ($sformatf("stall_req%0d", i), bus.imem_req_o, 1'b1);
      check32($sformatf("stall_addr%0d", i), bus.imem_addr_o, 32'h0);
      if (i < 2) tick();
    end
    wait_valid(20, "stall_deliver");
    check32("stall_instr_pc", instr_pc, 32'h100);
    check32("stall_instr", instr, mem_word(32'h100));

    // Trap while an instruction is held with decode stalled.
    do_reset(0);
    instr_ready = 1'b1;
    wait_valid(20, "trap_first");
    wait_valid(20, "trap_second");
    check32("trap_second_pc", instr_pc, 32'h4);
    tick();
    instr_ready = 1'b0;
    wait_valid(20, "trap_held");
    check32("trap_held_pc", instr_pc, 32'h8);
    tick();
    check1("trap_still_held", instr_valid, 1'b1);
    trap = 1'b1; mtvec = 32'h200;
    tick();
    trap = 1'b0;
    check1 ("trap_valid_drop", instr_valid, 1'b0);
    check32("trap_pc", pc, 32'h200);
    check1 ("trap_req", bus.imem_req_o, 1'b1);
    check32("trap_addr", bus.imem_addr_o, 32'h200);
    instr_ready = 1'b1;
    wait_valid(20, "trap_deliver");
    check32("trap_instr_pc", instr_pc, 32'h200);

    // Misaligned redirect target.
    redirect = 1'b1; redirect_pc = 32'h103;
    tick();
    redirect = 1'b0;
    check1 ("mis_pulse", misalign, 1'b1);
    check32("mis_pc", pc, 32'h100);
    tick();
    check1("mis_clear", misalign, 1'b0);
    wait_valid(20, "mis_deliver");
    check32("mis_instr_pc", instr_pc, 32'h100);

    // Halt while waiting on a response, then resume.
    lat_min = 3; lat_max = 3;
    redirect = 1'b1; redirect_pc = 32'h10;
    tick();
    redirect = 1'b0;
    check32("halt_req_addr", bus.imem_addr_o, 32'h10);
    tick();
    check1("halt_in_wait", bus.imem_req_o, 1'b0);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    begin
      bit saw_req = 1'b0, saw_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (bus.imem_req_o) saw_req = 1'b1;
        if (instr_valid) saw_valid = 1'b1;
      end
      check1("halt_no_req", saw_req, 1'b0);
      check1("halt_no_valid", saw_valid, 1'b0);
    end
    check32("halt_pc", pc, 32'h10);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    check1 ("resume_req", bus.imem_req_o, 1'b1);
    check32("resume_addr", bus.imem_addr_o, 32'h10);
    wait_valid(20, "resume_deliver");
    check32("resume_instr_pc", instr_pc, 32'h10);

    // Reset asserted in WAIT; the late response lands during reset.
    lat_min = 2; lat_max = 2;
    do_reset(0);
    tick();
    tick();
    check1("rst_in_wait", bus.imem_req_o, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    repeat (5) tick();
    check_reset_values("midrst_hold");
    lat_min = 0; lat_max = 0;
    rst_n = 1'b1;
    instr_ready = 1'b1;
    tick();
    check1 ("postrst_req", bus.imem_req_o, 1'b1);
    check32("postrst_addr", bus.imem_addr_o, 32'h0);
    wait_valid(20, "postrst_deliver");
    check32("postrst_instr_pc", instr_pc, 32'h0);

    // Randomized traffic against an instruction-stream model: every
    // consumed instruction must be the next one in program order, where
    // trap/redirect restart the order at the aligned target and a halt
    // that drops a held instruction skips it.
    lat_min = 0; lat_max = 3; gnt_pct = 60;
    do_reset(0);
    begin
      logic [31:0] exp_pc = 32'h0, prev_addr = 32'h0, tgt;
      logic        exp_mis = 1'b0, prev_req = 1'b0, prev_gnt = 1'b0, fl;
      int          deliveries = 0;
      int          r;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        tick();
        check1("rnd_misalign", misalign, exp_mis);
        if (prev_req && !prev_gnt) begin
          check1 ("rnd_req_hold", bus.imem_req_o, 1'b1);
          check32("rnd_addr_hold", bus.imem_addr_o, prev_addr);
        end
        instr_ready = 1'($urandom_range(1, 0));
        r = $urandom_range(99, 0);
        trap     = (r < 2);
        redirect = (r >= 2 && r < 6);
        halt     = (r >= 6 && r < 8);
        resume   = ($urandom_range(9, 0) < 3);
        mtvec    = $urandom;
        redirect_pc = ($urandom_range(7, 0) == 0) ? 32'hFFFF_FFF8 : $urandom;

        fl  = trap | redirect;
        tgt = trap ? mtvec : redirect_pc;
        if (fl) begin
          exp_pc = {tgt[31:2], 2'b00};
        end else if (instr_valid) begin
          if (halt) begin
            exp_pc = exp_pc + 32'd4;
          end else if (instr_ready) begin
            check32("rnd_instr_pc", instr_pc, exp_pc);
            check32("rnd_instr", instr, mem_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
            deliveries++;
          end
        end
        exp_mis   = fl && (tgt[1:0] != 2'b00);
        prev_req  = bus.imem_req_o;
        prev_gnt  = bus.imem_gnt_i;
        prev_addr = bus.imem_addr_o;
      end
      checks++;
      if (deliveries < 50) begin
        failures++;
        $display("FAIL rnd_progress: got %0d deliveries expected at least 50", deliveries);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer for the rv32i core: owns the program counter and drives a single-outstanding request/grant/response handshake to instruction memory. It presents fetched instructions to decode with a valid/ready handshake. Redirects (branch/jump), traps and halt/resume all enter through this block, replacing the free-running PC increment.

## Interface
- RESET_ADDR, 32'h0000_0000, PC value loaded on reset
- clk  in  1  clock, all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- imem_req_o  out  1  fetch request valid
- imem_addr_o  out  32  fetch address; stable while imem_req_o=1 and imem_gnt_i=0
- imem_gnt_i  in  1  request accepted this cycle
- imem_rvalid_i  in  1  response valid; at most one per granted request, ≥1 cycle after grant
- imem_rdata_i  in  32  response instruction word
- instr_valid_o  out  1  instruction held for decode
- instr_o  out  32  held instruction
- instr_pc_o  out  32  address of held instruction
- instr_ready_i  in  1  decode consumes held instruction
- redirect_i  in  1  branch/jump taken
- redirect_pc_i  in  32  redirect target
- trap_i  in  1  trap taken
- mtvec_i  in  32  trap target
- halt_i  in  1  stop fetching
- resume_i  in  1  restart fetching from HALTED
- pc_o  out  32  next fetch address (PC register)
- misalign_o  out  1  one-cycle pulse: trap/redirect target had bits [1:0]≠0

## Operation
- States: IDLE, REQ, WAIT, OUT, HALTED.
- Reset values: state=IDLE, pc_o=RESET_ADDR, kill=0, imem_req_o=0, imem_addr_o=RESET_ADDR, instr_valid_o=0, instr_o=0, instr_pc_o=0, misalign_o=0.
- IDLE → REQ unconditionally on the first edge after reset release.
- REQ: imem_req_o=1, imem_addr_o=pc_o. On imem_gnt_i → WAIT.
- WAIT: on imem_rvalid_i with kill=0 → capture instr_o=imem_rdata_i, instr_pc_o=pc_o, pc_o=pc_o+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), go to OUT. With kill=1 → discard the response, clear kill, go to REQ (or HALTED if halt is pending).
- OUT: instr_valid_o=1. On instr_ready_i → REQ.
- Control priority, same cycle: trap_i > redirect_i > halt_i > sequential.
- Trap/redirect: pc_o ← {target[31:2],2'b00}; misalign_o pulses next cycle if target[1:0]≠0. In OUT, the held instruction is dropped even if instr_ready_i=1, then → REQ. In IDLE/HALTED → REQ. In REQ without grant, the address stays stable: the new pc is loaded, kill=1, and the current request completes. In REQ with grant, or in WAIT, set kill=1 (or keep it set) and the in-flight response is discarded. A later redirect overrides pc_o; kill stays 1.
- Halt: set halt_pend. Any in-flight request completes and its response is discarded (kill=1). From OUT, the held instruction is dropped. The block enters HALTED once no transaction is outstanding. pc_o holds the next unfetched address.
- HALTED: imem_req_o=0. resume_i → REQ at pc_o. trap_i/redirect_i → REQ at the target.
- instr_valid_o is 1 only in OUT.

## Timing
- Fully registered outputs. There are no combinational paths from inputs to outputs.
- First imem_req_o: 1 cycle after rst_n rises (IDLE→REQ edge).
- Zero-wait memory (grant in the first REQ cycle, rvalid the next cycle) with instr_ready_i=1 gives 1 instruction per 3 cycles (REQ, WAIT, OUT).
- Control inputs are sampled every cycle. Their effect on pc_o is visible the next cycle.
- rst_n assertion mid-transaction returns the block to reset values immediately. A late rvalid after reset is ignored because the state is not WAIT.

## Structure
- Package fetch_pkg: fetch_state_e enum, XLEN=32, INSTR_ALIGN=4, default RESET_ADDR constant.
- Sub-module pc_reg: 32-bit PC register with async active-low reset to RESET_ADDR, load (aligned target) and increment-by-4 controls. The FSM, kill/halt_pend flags and output register live in fetch_ctrl.

## Test plan
- Reset release, zero-wait memory returning 32'h0000_0013 at each address, ready=1 → addresses 0,4,8 requested; instr_valid_o every 3rd cycle with instr_pc_o 0,4,8.
- Grant withheld 3 cycles while a redirect to 32'h100 arrives in cycle 1 → imem_addr_o stays 0 until grant; that response is discarded; next request at 32'h100, instr_pc_o=32'h100.
- Instruction at 32'h8 held in OUT with ready=0, trap_i with mtvec_i=32'h200 → instr_valid_o drops next cycle, fetch at 32'h200, no instruction from 32'hC delivered.
- Redirect to 32'h103 → misalign_o pulses once, fetch at 32'h100.
- halt_i in WAIT at pc 32'h10 → response discarded, HALTED, pc_o=32'h10, no imem_req_o for 20 cycles; resume_i → fetch 32'h10.
- rst_n low in WAIT, rvalid arrives during reset → all outputs at reset values, first post-reset fetch at RESET_ADDR.
